// File: rtl/apb3_cmd_master_pkg.sv
// apb3_cmd_pkg: shared types for the APB3 command master.
//   state_e  - master FSM states
//   cmd_t    - queued command {write, addr, wdata, expdata, mask}
//   rsp_t    - captured per-transaction response
// Structs are sized to the widest supported bus (MAX_AW / MAX_DW). The
// module zero-extends narrower buses into them, so the unused upper bits
// are constant zero and drop out in synthesis.
package apb3_cmd_pkg;

    localparam int MAX_AW    = 32;
    localparam int MAX_DW    = 64;
    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic              write;
        logic [MAX_AW-1:0] addr;
        logic [MAX_DW-1:0] wdata;
        logic [MAX_DW-1:0] expdata;  // "expect" is a keyword
        logic [MAX_DW-1:0] mask;
    } cmd_t;

    typedef struct packed {
        logic [MAX_DW-1:0] rdata;
        logic              slverr;
        logic              mismatch;
        logic              timeout;
    } rsp_t;

    // Compare only the bits selected by mask.
    function automatic logic is_mismatch(input logic [MAX_DW-1:0] rdata,
                                         input logic [MAX_DW-1:0] expdata,
                                         input logic [MAX_DW-1:0] mask);
        return |((rdata ^ expdata) & mask);
    endfunction

endpackage

// File: rtl/apb3_cmd_master_if.sv
// apb3_cmd_master_if: command, response, status and APB3 bus signals of
// the command master.
//   modport master - the command master (drives APB, consumes commands)
//   modport slave  - the environment (issues commands, models the APB slave)
interface apb3_cmd_master_if #(
    parameter int APB_AW = 8,
    parameter int APB_DW = 32
);
    // command channel
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_write;
    logic [APB_AW-1:0] i_cmd_addr;
    logic [APB_DW-1:0] i_cmd_wdata;
    logic [APB_DW-1:0] i_cmd_expect;
    logic [APB_DW-1:0] i_cmd_mask;
    // response channel
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [APB_DW-1:0] o_rsp_rdata;
    logic              o_rsp_slverr;
    logic              o_rsp_mismatch;
    logic              o_rsp_timeout;
    // status
    logic [15:0]       o_err_cnt;
    logic              o_busy;
    // APB3
    logic [APB_AW-1:0] o_paddr;
    logic [APB_DW-1:0] o_pwdata;
    logic              o_pwrite;
    logic              o_psel;
    logic              o_penable;
    logic [APB_DW-1:0] i_prdata;
    logic              i_pready;
    logic              i_pslverr;

    modport master (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_expect, i_cmd_mask,
        input  i_rsp_ready, i_prdata, i_pready, i_pslverr,
        output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_slverr, o_rsp_mismatch,
        output o_rsp_timeout, o_err_cnt, o_busy,
        output o_paddr, o_pwdata, o_pwrite, o_psel, o_penable
    );

    modport slave (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_expect, i_cmd_mask,
        output i_rsp_ready, i_prdata, i_pready, i_pslverr,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_slverr, o_rsp_mismatch,
        input  o_rsp_timeout, o_err_cnt, o_busy,
        input  o_paddr, o_pwdata, o_pwrite, o_psel, o_penable
    );
endinterface

// File: rtl/apb3_cmd_master_sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags.
//   clk, rst        - clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  - push; taken when not full, or when full and a pop
//                     frees a slot in the same cycle
//   rd_en, rd_data  - pop; rd_data shows the head entry (show-ahead)
//   full, empty     - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/apb3_cmd_master.sv
// apb3_cmd_master: queues read/write commands and replays them as APB3
// transfers, returning one response per command.
//   i_clk, i_rst - clock, synchronous active-high reset
//   bus.i_cmd_* / o_cmd_ready   - command push (write, addr, wdata, expect, mask)
//   bus.o_rsp_* / i_rsp_ready   - response: rdata (0 for writes), slverr,
//                                 mismatch (masked read compare), timeout
//   bus.o_err_cnt               - saturating count of failed responses
//   bus.o_busy                  - queue non-empty or a transfer in flight
//   bus.o_p* / i_p*             - APB3 master port
module apb3_cmd_master
    import apb3_cmd_pkg::*;
#(
    parameter int APB_AW    = 8,
    parameter int APB_DW    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    apb3_cmd_master_if.master bus
);
    localparam int CMD_W  = $bits(cmd_t);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_e              state, state_nxt;
    cmd_t                cmd_in, cmd_head, work;
    rsp_t                rsp, rsp_cap;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                fifo_full, fifo_empty;
    logic                push, pop;
    logic                wait_hit;
    logic                rsp_hs;
    logic                unused_wide;

    // ---------------- command queue ----------------
    assign push = bus.i_cmd_valid && !fifo_full;

    always_comb begin
        cmd_in         = '0;
        cmd_in.write   = bus.i_cmd_write;
        cmd_in.addr    = MAX_AW'(bus.i_cmd_addr);
        cmd_in.wdata   = MAX_DW'(bus.i_cmd_wdata);
        cmd_in.expdata = MAX_DW'(bus.i_cmd_expect);
        cmd_in.mask    = MAX_DW'(bus.i_cmd_mask);
    end

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (push),
        .wr_data (cmd_in),
        .rd_en   (pop),
        .rd_data (cmd_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------- FSM ----------------
    // wait_cnt counts completed ACCESS cycles, so the hit fires on the
    // TIMEOUT-th ACCESS cycle without PREADY.
    assign wait_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign rsp_hs   = (state == ST_RESP) && bus.i_rsp_ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_SETUP;
                    pop       = 1'b1;
                end
            end
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (bus.i_pready || wait_hit) state_nxt = ST_RESP;
            ST_RESP:   if (bus.i_rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Response as it would be captured on this ACCESS cycle.
    always_comb begin
        rsp_cap = '0;
        if (bus.i_pready) begin
            rsp_cap.slverr = bus.i_pslverr;
            if (!work.write) begin
                rsp_cap.rdata    = MAX_DW'(bus.i_prdata);
                rsp_cap.mismatch = is_mismatch(rsp_cap.rdata, work.expdata, work.mask);
            end
        end else begin
            rsp_cap.timeout = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            work     <= '0;
            rsp      <= '0;
            wait_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            // pop coincides with SETUP entry: load the command, clear the wait
            if (pop) begin
                work     <= cmd_head;
                wait_cnt <= '0;
            end
            if (state == ST_ACCESS) begin
                if (state_nxt == ST_RESP) rsp <= rsp_cap;
                else                      wait_cnt <= wait_cnt + 1'b1;
            end
            if (rsp_hs && (rsp.slverr || rsp.mismatch || rsp.timeout) && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    assign bus.o_cmd_ready    = !fifo_full;
    assign bus.o_busy         = !fifo_empty || (state != ST_IDLE);
    assign bus.o_psel         = (state == ST_SETUP) || (state == ST_ACCESS);
    assign bus.o_penable      = (state == ST_ACCESS);
    assign bus.o_paddr        = work.addr[APB_AW-1:0];
    assign bus.o_pwdata       = work.wdata[APB_DW-1:0];
    assign bus.o_pwrite       = work.write;
    assign bus.o_rsp_valid    = (state == ST_RESP);
    assign bus.o_rsp_rdata    = rsp.rdata[APB_DW-1:0];
    assign bus.o_rsp_slverr   = rsp.slverr;
    assign bus.o_rsp_mismatch = rsp.mismatch;
    assign bus.o_rsp_timeout  = rsp.timeout;
    assign bus.o_err_cnt      = err_cnt;

    // Bits above the configured bus widths are always zero.
    assign unused_wide = ^{work, rsp};

endmodule

// File: tb/tb_apb3_cmd_master.sv
module tb_apb3_cmd_master;

    logic        clk;
    logic        rst;
    logic        echo;        // slave returns a value derived from PADDR
    logic [31:0] prdata_fix;  // slave read data when echo=0
    int          n_chk;
    int          n_fail;

    apb3_cmd_master_if #(.APB_AW(8), .APB_DW(32)) bus();

    apb3_cmd_master #(
        .APB_AW    (8),
        .APB_DW    (32),
        .CMD_DEPTH (4),
        .TIMEOUT   (16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign bus.i_prdata = echo ? (32'hC0DE_0000 ^ {24'h0, bus.o_paddr}) : prdata_fix;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                            input logic [31:0] ex, input logic [31:0] mk);
        bus.i_cmd_valid  = 1'b1;
        bus.i_cmd_write  = wr;
        bus.i_cmd_addr   = a;
        bus.i_cmd_wdata  = wd;
        bus.i_cmd_expect = ex;
        bus.i_cmd_mask   = mk;
        @(negedge clk);
        bus.i_cmd_valid  = 1'b0;
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.o_rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_rsp;
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (bus.o_psel !== 1'b0) begin n_fail++; $display("FAIL reset_psel got %b want 0", bus.o_psel); end
        n_chk++; if (bus.o_penable !== 1'b0) begin n_fail++; $display("FAIL reset_penable got %b want 0", bus.o_penable); end
        n_chk++; if (bus.o_paddr !== 8'h0 || bus.o_pwdata !== 32'h0 || bus.o_pwrite !== 1'b0) begin
            n_fail++; $display("FAIL reset_apb got addr=%h wdata=%h wr=%b want 0", bus.o_paddr, bus.o_pwdata, bus.o_pwrite); end
        n_chk++; if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rsp got valid=%b rdata=%h want 0", bus.o_rsp_valid, bus.o_rsp_rdata); end
        n_chk++; if (bus.o_err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_err_cnt got %h want 0", bus.o_err_cnt); end
        n_chk++; if (bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_status got busy=%b ready=%b want 0/1", bus.o_busy, bus.o_cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        push_cmd(1'b1, 8'h04, 32'hA5A5_A5A5, 32'h0, 32'h0);
        // cycle after the push: still IDLE, popping
        n_chk++; if (bus.o_psel !== 1'b0 || bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL wr_idle got psel=%b busy=%b want 0/1", bus.o_psel, bus.o_busy); end
        @(negedge clk);
        n_chk++; if ({bus.o_psel, bus.o_penable} !== 2'b10) begin
            n_fail++; $display("FAIL wr_setup got psel/pen=%b want 10", {bus.o_psel, bus.o_penable}); end
        n_chk++; if (bus.o_paddr !== 8'h04 || bus.o_pwrite !== 1'b1 || bus.o_pwdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL wr_setup_bus got addr=%h wr=%b wdata=%h want 04/1/a5a5a5a5", bus.o_paddr, bus.o_pwrite, bus.o_pwdata); end
        @(negedge clk);
        n_chk++; if ({bus.o_psel, bus.o_penable} !== 2'b11) begin
            n_fail++; $display("FAIL wr_access got psel/pen=%b want 11", {bus.o_psel, bus.o_penable}); end
        n_chk++; if (bus.o_paddr !== 8'h04 || bus.o_pwrite !== 1'b1 || bus.o_pwdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL wr_access_bus got addr=%h wr=%b wdata=%h want 04/1/a5a5a5a5", bus.o_paddr, bus.o_pwrite, bus.o_pwdata); end
        @(negedge clk);
        n_chk++; if (bus.o_rsp_valid !== 1'b1 || bus.o_psel !== 1'b0) begin
            n_fail++; $display("FAIL wr_latency got rsp_valid=%b psel=%b want 1/0", bus.o_rsp_valid, bus.o_psel); end
        n_chk++; if ({bus.o_rsp_slverr, bus.o_rsp_mismatch, bus.o_rsp_timeout} !== 3'b000 || bus.o_rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL wr_rsp got flags=%b rdata=%h want 000/0",
                               {bus.o_rsp_slverr, bus.o_rsp_mismatch, bus.o_rsp_timeout}, bus.o_rsp_rdata); end
        // paddr/pwdata hold after the transfer
        n_chk++; if (bus.o_paddr !== 8'h04 || bus.o_pwdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL wr_hold got addr=%h wdata=%h want 04/a5a5a5a5", bus.o_paddr, bus.o_pwdata); end
        ack_rsp();
        n_chk++; if (bus.o_rsp_valid !== 1'b0 || bus.o_err_cnt !== 16'h0) begin
            n_fail++; $display("FAIL wr_done got rsp_valid=%b err_cnt=%h want 0/0", bus.o_rsp_valid, bus.o_err_cnt); end
    endtask

    task automatic test_read_mismatch;
        bit got;
        prdata_fix = 32'h34;
        push_cmd(1'b0, 8'h08, 32'h0, 32'h12, 32'hFF);
        wait_rsp(got);
        n_chk++; if (!got) begin n_fail++; $display("FAIL rd_mm_rsp got none want rsp_valid"); end
        n_chk++; if (bus.o_rsp_mismatch !== 1'b1 || bus.o_rsp_rdata !== 32'h34) begin
            n_fail++; $display("FAIL rd_mm got mismatch=%b rdata=%h want 1/34", bus.o_rsp_mismatch, bus.o_rsp_rdata); end
        ack_rsp();
        n_chk++; if (bus.o_err_cnt !== 16'd1) begin n_fail++; $display("FAIL rd_mm_err got %h want 1", bus.o_err_cnt); end
        push_cmd(1'b0, 8'h08, 32'h0, 32'h12, 32'h00);
        wait_rsp(got);
        n_chk++; if (!got || bus.o_rsp_mismatch !== 1'b0 || bus.o_rsp_rdata !== 32'h34) begin
            n_fail++; $display("FAIL rd_masked got valid=%b mismatch=%b rdata=%h want 1/0/34", got, bus.o_rsp_mismatch, bus.o_rsp_rdata); end
        ack_rsp();
        n_chk++; if (bus.o_err_cnt !== 16'd1) begin n_fail++; $display("FAIL rd_masked_err got %h want 1", bus.o_err_cnt); end
    endtask

    task automatic test_slverr;
        bit got;
        bus.i_pslverr = 1'b1;
        push_cmd(1'b1, 8'h0C, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF);
        wait_rsp(got);
        n_chk++; if (!got || bus.o_rsp_slverr !== 1'b1 || bus.o_rsp_mismatch !== 1'b0 || bus.o_rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL slverr got valid=%b slverr=%b mismatch=%b rdata=%h want 1/1/0/0",
                               got, bus.o_rsp_slverr, bus.o_rsp_mismatch, bus.o_rsp_rdata); end
        ack_rsp();
        bus.i_pslverr = 1'b0;
        n_chk++; if (bus.o_err_cnt !== 16'd2) begin n_fail++; $display("FAIL slverr_err got %h want 2", bus.o_err_cnt); end
    endtask

    task automatic test_timeout;
        int acc;
        bit got;
        acc = 0;
        got = 1'b0;
        bus.i_pready = 1'b0;
        push_cmd(1'b0, 8'h20, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 64; i++) begin
            if (bus.o_rsp_valid === 1'b1) begin got = 1'b1; break; end
            if (bus.o_psel === 1'b1 && bus.o_penable === 1'b1) acc++;
            @(negedge clk);
        end
        n_chk++; if (!got) begin n_fail++; $display("FAIL to_rsp got none want rsp_valid"); end
        n_chk++; if (acc != 16) begin n_fail++; $display("FAIL to_access_cycles got %0d want 16", acc); end
        n_chk++; if (bus.o_rsp_timeout !== 1'b1 || bus.o_psel !== 1'b0) begin
            n_fail++; $display("FAIL to_flag got timeout=%b psel=%b want 1/0", bus.o_rsp_timeout, bus.o_psel); end
        ack_rsp();
        n_chk++; if (bus.o_err_cnt !== 16'd3 || bus.o_psel !== 1'b0) begin
            n_fail++; $display("FAIL to_err got err_cnt=%h psel=%b want 3/0", bus.o_err_cnt, bus.o_psel); end
        bus.i_pready = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] got_q [6];
        int          n_got;
        bit          got;
        bit          f_acc;
        n_got = 0;
        f_acc = 1'b0;
        echo  = 1'b1;
        // A stalls in RESP, then B..E fill the queue
        push_cmd(1'b0, 8'h10, 32'h0, 32'h0, 32'h0);
        wait_rsp(got);
        for (int k = 1; k <= 4; k++) push_cmd(1'b0, 8'(8'h10 + k), 32'h0, 32'h0, 32'h0);
        n_chk++; if (!got || bus.o_cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_full got rsp_valid=%b cmd_ready=%b want 1/0", got, bus.o_cmd_ready); end
        // offer F while draining
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = 8'h15;
        bus.i_rsp_ready = 1'b1;
        for (int c = 0; c < 200 && n_got < 6; c++) begin
            if (bus.o_rsp_valid === 1'b1) begin
                got_q[n_got] = bus.o_rsp_rdata;
                n_got++;
            end
            if (bus.i_cmd_valid && bus.o_cmd_ready === 1'b1) f_acc = 1'b1;
            @(negedge clk);
            if (f_acc) bus.i_cmd_valid = 1'b0;
        end
        bus.i_rsp_ready = 1'b0;
        bus.i_cmd_valid = 1'b0;
        n_chk++; if (n_got != 6 || !f_acc) begin
            n_fail++; $display("FAIL b2b_count got %0d rsp (fifth push taken=%b) want 6/1", n_got, f_acc); end
        for (int i = 0; i < n_got; i++) begin
            n_chk++;
            if (got_q[i] !== (32'hC0DE_0010 + 32'(i))) begin
                n_fail++; $display("FAIL b2b_order[%0d] got %h want %h", i, got_q[i], 32'hC0DE_0010 + 32'(i));
            end
        end
        repeat (2) @(negedge clk);
        n_chk++; if (bus.o_busy !== 1'b0 || bus.o_err_cnt !== 16'd3) begin
            n_fail++; $display("FAIL b2b_idle got busy=%b err_cnt=%h want 0/3", bus.o_busy, bus.o_err_cnt); end
        echo = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit reached;
        bit stray;
        reached = 1'b0;
        stray   = 1'b0;
        bus.i_pready = 1'b0;
        push_cmd(1'b0, 8'h30, 32'h0, 32'h0, 32'h0);
        push_cmd(1'b0, 8'h34, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (bus.o_psel === 1'b1 && bus.o_penable === 1'b1) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        n_chk++; if (!reached) begin n_fail++; $display("FAIL rstmid_access got no ACCESS want ACCESS"); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.o_psel !== 1'b0 || bus.o_penable !== 1'b0 || bus.o_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_bus got psel=%b pen=%b rsp_valid=%b want 0/0/0", bus.o_psel, bus.o_penable, bus.o_rsp_valid); end
        n_chk++; if (bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1 || bus.o_err_cnt !== 16'h0) begin
            n_fail++; $display("FAIL rstmid_state got busy=%b ready=%b err_cnt=%h want 0/1/0", bus.o_busy, bus.o_cmd_ready, bus.o_err_cnt); end
        rst = 1'b0;
        bus.i_pready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_rsp_valid !== 1'b0 || bus.o_psel !== 1'b0) stray = 1'b1;
        end
        n_chk++; if (stray) begin n_fail++; $display("FAIL rstmid_after got activity=1 want 0"); end
    endtask

    task automatic test_saturation;
        bit got;
        force dut.err_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt;
        prdata_fix = 32'h34;
        for (int k = 0; k < 2; k++) begin
            push_cmd(1'b0, 8'h08, 32'h0, 32'h12, 32'hFF);
            wait_rsp(got);
            ack_rsp();
            n_chk++;
            if (!got || bus.o_err_cnt !== 16'hFFFF) begin
                n_fail++; $display("FAIL sat[%0d] got valid=%b err_cnt=%h want 1/ffff", k, got, bus.o_err_cnt);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        echo   = 1'b0;
        prdata_fix       = 32'h0;
        bus.i_cmd_valid  = 1'b0;
        bus.i_cmd_write  = 1'b0;
        bus.i_cmd_addr   = 8'h0;
        bus.i_cmd_wdata  = 32'h0;
        bus.i_cmd_expect = 32'h0;
        bus.i_cmd_mask   = 32'h0;
        bus.i_rsp_ready  = 1'b0;
        bus.i_pready     = 1'b1;
        bus.i_pslverr    = 1'b0;

        test_reset();
        test_write();
        test_read_mismatch();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
